// File: rtl/uart_frame_rx_if.sv
// Byte stream interface for uart_frame_rx: upstream uart byte strobe on one
// side, buffered payload stream plus frame status on the other.
interface uart_frame_rx_if;
  logic [7:0] rx_d;
  logic       rx_dv;
  logic       rx_parity_ok;
  logic [7:0] m_d;
  logic       m_dv;
  logic       m_dr;
  logic       m_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       rx_overrun;

  // Driver side: feeds received bytes, accepts payload and status.
  modport master (
    output rx_d, rx_dv, rx_parity_ok, m_dr,
    input  m_d, m_dv, m_last, frame_ok, frame_err, err_code, rx_overrun
  );

  // Deframer side.
  modport slave (
    input  rx_d, rx_dv, rx_parity_ok, m_dr,
    output m_d, m_dv, m_last, frame_ok, frame_err, err_code, rx_overrun
  );
endinterface

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: deframes SYNC, LEN, payload, CHK byte frames coming from a
// uart receiver. The payload is held in a local buffer and only streamed out
// once the checksum matches; bad frames are dropped whole with an error code.
module uart_frame_rx #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 64,
  parameter int         TIMEOUT_CLKS = 100000,
  parameter bit         USE_PARITY   = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  uart_frame_rx_if.slave bus
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t        state;
  logic [7:0]    len;
  logic [7:0]    sum;
  logic [7:0]    wr_ptr;
  logic [7:0]    rd_ptr;
  logic [TW-1:0] tcnt;
  logic          m_dv_r;
  logic          m_last_r;
  logic          frame_ok_r;
  logic          frame_err_r;
  logic [1:0]    err_code_r;
  logic          overrun_r;

  // Payload buffer; never cleared, only written while collecting a frame.
  logic [7:0] buf_mem [MAX_LEN];

  logic in_frame;
  logic parity_bad;
  logic tmo_hit;

  // Checksum accumulation wraps modulo 256.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  assign in_frame   = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  assign parity_bad = USE_PARITY && !bus.rx_parity_ok;
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign tmo_hit    = in_frame && !bus.rx_dv && (tcnt == TMO_LAST);

  // Frame FSM with registered stream and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len         <= '0;
      sum         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tcnt        <= '0;
      m_dv_r      <= 1'b0;
      m_last_r    <= 1'b0;
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
      err_code_r  <= 2'd0;
      overrun_r   <= 1'b0;
    end else begin
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;

      if (in_frame && !bus.rx_dv) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end

      if (in_frame && bus.rx_dv && parity_bad) begin
        frame_err_r <= 1'b1;
        err_code_r  <= 2'd3;
        state       <= S_IDLE;
      end else if (tmo_hit) begin
        frame_err_r <= 1'b1;
        err_code_r  <= 2'd0;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.rx_dv && (bus.rx_d == SYNC_BYTE)) begin
              state <= S_LEN;
            end
          end
          S_LEN: begin
            if (bus.rx_dv) begin
              if ((bus.rx_d == 8'd0) || (bus.rx_d > MAX_LEN_B)) begin
                frame_err_r <= 1'b1;
                err_code_r  <= 2'd1;
                state       <= S_IDLE;
              end else begin
                len    <= bus.rx_d;
                sum    <= bus.rx_d;
                wr_ptr <= '0;
                state  <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (bus.rx_dv) begin
              sum    <= sum8(sum, bus.rx_d);
              wr_ptr <= wr_ptr + 8'd1;
              if (wr_ptr == len - 8'd1) begin
                state <= S_CHK;
              end
            end
          end
          S_CHK: begin
            if (bus.rx_dv) begin
              if (sum8(sum, bus.rx_d) == 8'd0) begin
                frame_ok_r <= 1'b1;
                m_dv_r     <= 1'b1;
                m_last_r   <= (len == 8'd1);
                rd_ptr     <= '0;
                state      <= S_DRAIN;
              end else begin
                frame_err_r <= 1'b1;
                err_code_r  <= 2'd2;
                state       <= S_IDLE;
              end
            end
          end
          S_DRAIN: begin
            // Bytes arriving while the buffer drains cannot be stored.
            if (bus.rx_dv) begin
              overrun_r <= 1'b1;
            end
            if (m_dv_r && bus.m_dr) begin
              if (m_last_r) begin
                m_dv_r   <= 1'b0;
                m_last_r <= 1'b0;
                rd_ptr   <= '0;
                state    <= S_IDLE;
              end else begin
                rd_ptr   <= rd_ptr + 8'd1;
                m_last_r <= (rd_ptr + 8'd2 == len);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Payload capture into the buffer; data path, so no reset.
  always_ff @(posedge clk) begin
    if ((state == S_PAYLOAD) && bus.rx_dv) begin
      buf_mem[wr_ptr[AW-1:0]] <= bus.rx_d;
    end
  end

  // rd_ptr only moves on a transfer, so m_d holds steady through a stall.
  assign bus.m_d        = buf_mem[rd_ptr[AW-1:0]];
  assign bus.m_dv       = m_dv_r;
  assign bus.m_last     = m_last_r;
  assign bus.frame_ok   = frame_ok_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.err_code   = err_code_r;
  assign bus.rx_overrun = overrun_r;

endmodule
